// File: rtl/rps_match_host.sv
// Rock-paper-scissors match host: feeds a player-1 move plus an LFSR-generated player-2
// move to an external game engine, collects its verdicts and keeps score until a match is won.
module rps_match_host #(
    parameter int         WIN_TARGET  = 3,
    parameter int         RESULT_WAIT = 2,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] p1_move,
    input  logic       p1_valid,
    output logic       p1_ready,
    input  logic       match_clr,
    output logic [1:0] game_p1,
    output logic [1:0] game_p2,
    output logic       game_start,
    input  logic [1:0] game_winner,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [3:0] ties,
    output logic [1:0] last_result,
    output logic       round_err,
    output logic       match_done,
    output logic [1:0] match_winner
);

    // An all-zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [7:0] SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [3:0] WIN       = 4'(WIN_TARGET);
    localparam logic [3:0] WAIT_LOAD = 4'(RESULT_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lfsr;
    logic [3:0] cnt;
    logic [3:0] score_p1_nxt;
    logic [3:0] score_p2_nxt;
    logic [3:0] ties_nxt;
    logic       target_hit;
    logic [1:0] p2_pick;

    // Post-update scores let CAPTURE decide between DONE and IDLE in the same cycle.
    always_comb begin
        score_p1_nxt = score_p1;
        score_p2_nxt = score_p2;
        ties_nxt     = ties;
        case (game_winner)
            2'b01:   if (score_p1 != 4'hF) score_p1_nxt = score_p1 + 4'd1;
            2'b10:   if (score_p2 != 4'hF) score_p2_nxt = score_p2 + 4'd1;
            2'b00:   if (ties != 4'hF) ties_nxt = ties + 4'd1;
            default: ;
        endcase
        target_hit = (score_p1_nxt == WIN) || (score_p2_nxt == WIN);
    end

    always_comb begin
        p2_pick = (lfsr[1:0] == 2'b11) ? 2'b00 : lfsr[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (p1_valid) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_WAIT;
            S_WAIT:    if (cnt == 4'd0) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = target_hit ? S_DONE : S_IDLE;
            S_DONE:    if (match_clr) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        p1_ready   = (state == S_IDLE);
        game_start = (state == S_ISSUE) && ena;
        match_done = (state == S_DONE);
    end

    // Fibonacci LFSR, taps 8/6/5/4; runs in every state while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (ena) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            game_p1 <= 2'b00;
            game_p2 <= 2'b00;
            cnt     <= 4'd0;
        end else if (ena) begin
            if (state == S_IDLE && p1_valid) begin
                game_p1 <= p1_move;
                game_p2 <= p2_pick;
            end
            if (state == S_ISSUE) begin
                cnt <= WAIT_LOAD;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_p1     <= 4'd0;
            score_p2     <= 4'd0;
            ties         <= 4'd0;
            last_result  <= 2'b00;
            round_err    <= 1'b0;
            match_winner <= 2'b00;
        end else if (ena) begin
            round_err <= 1'b0;
            if (state == S_CAPTURE) begin
                last_result <= game_winner;
                score_p1    <= score_p1_nxt;
                score_p2    <= score_p2_nxt;
                ties        <= ties_nxt;
                round_err   <= (game_winner == 2'b11);
                if (target_hit) begin
                    match_winner <= (score_p1_nxt == WIN) ? 2'b01 : 2'b10;
                end
            end else if (state == S_DONE && match_clr) begin
                score_p1     <= 4'd0;
                score_p2     <= 4'd0;
                ties         <= 4'd0;
                last_result  <= 2'b00;
                match_winner <= 2'b00;
            end
        end
    end

endmodule
